// File: rtl/cs_approx_avg.sv
// cs_approx_avg: streaming approximate-average filter over a 9-sample window.
// Y = floor((S + 9*Xappr) / 8), where S is the window sum and Xappr is the
// largest window sample not exceeding the window mean (exact test 9*Wi <= S).
module cs_approx_avg (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] X,
    output logic [9:0] Y
);

    // w_q[8] is the newest sample, w_q[0] the oldest
    logic [7:0]  w_q [9];
    logic [7:0]  w_d [9];

    logic [11:0] sum;
    logic [7:0]  xappr;
    logic [12:0] y_full;

    // Next window: shift toward index 0 and append the new sample at the top
    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            w_d[i] = w_q[i + 1];
        end
        w_d[8] = X;
    end

    // Window register; reset clears all history immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 9; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 9; i++) begin
                w_q[i] <= w_d[i];
            end
        end
    end

    // Window sum (max 2295, fits 12 bits)
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            sum = sum + {4'b0000, w_q[i]};
        end
    end

    // Largest eligible sample; 9*Wi is formed as Wi*8 + Wi to avoid a multiplier.
    // Starting from 0 is safe because the window minimum is always eligible.
    always_comb begin
        logic [11:0] w9;
        xappr = '0;
        for (int unsigned i = 0; i < 9; i++) begin
            w9 = {1'b0, w_q[i], 3'b000} + {4'b0000, w_q[i]};
            if ((w9 <= sum) && (w_q[i] > xappr)) begin
                xappr = w_q[i];
            end
        end
    end

    // Output: (S + 9*Xappr) >> 3, intermediate max 4590 fits 13 bits
    always_comb begin
        y_full = {1'b0, sum} + {2'b00, xappr, 3'b000} + {5'b00000, xappr};
        Y      = y_full[12:3];
    end

endmodule

// File: tb/tb_cs_approx_avg.sv
// Self-checking bench for cs_approx_avg: expected results from a queue-based
// window model are pushed at stimulus time and popped by an independent monitor.
`timescale 1ns/1ps
module tb_cs_approx_avg;

    logic       clk;
    logic       reset;
    logic [7:0] X;
    logic [9:0] Y;

    int vectors     = 0;
    int miscompares = 0;

    int win[$];       // reference window, front = oldest
    int exp_q[$];     // expected Y per capture

    cs_approx_avg dut (
        .clk   (clk),
        .reset (reset),
        .X     (X),
        .Y     (Y)
    );

    initial clk = 1'b0;
    always #3 clk = ~clk;

    // Reference: plain arithmetic over the last nine samples
    function automatic int model_y();
        int s;
        int xa;
        s  = 0;
        xa = 0;
        foreach (win[i]) s += win[i];
        foreach (win[i]) if (9 * win[i] <= s && win[i] > xa) xa = win[i];
        return (s + 9 * xa) / 8;
    endfunction

    function automatic void model_clear();
        win.delete();
        for (int i = 0; i < 9; i++) win.push_back(0);
    endfunction

    function automatic void model_shift(input int x);
        void'(win.pop_front());
        win.push_back(x);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: Y=%0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one sample on the falling edge; it is captured at the next rising edge
    task automatic feed(input int x);
        @(negedge clk);
        X = 8'(x);
        model_shift(x);
        exp_q.push_back(model_y());
    endtask

    // Directed check of the window result right after the capture
    task automatic check_after_capture(input string name, input int exp);
        @(posedge clk);
        #1;
        check(name, int'(Y), exp);
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check({name, "_immediate"}, int'(Y), 0);
        model_clear();
        @(posedge clk);
        #1;
        check({name, "_held"}, int'(Y), 0);
        @(negedge clk);
        X     = 8'd0;
        reset = 1'b0;
        // one capture of 0 happens before the next feed; window is all zero anyway
        model_shift(0);
    endtask

    // Monitor: every capture yields one result, checked 1 ns after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                int e;
                e = exp_q.pop_front();
                vectors++;
                if (int'(Y) != e) begin
                    miscompares++;
                    $display("FAIL stream: Y=%0d expected %0d at %0t", Y, e, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        X     = 8'd0;
        model_clear();
        #1;
        check("reset_initial", int'(Y), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_shift(0);

        // Ramp 1..9 -> 11
        for (int i = 1; i <= 9; i++) feed(i);
        check_after_capture("ramp", 11);

        // Slide in 100 -> window 2..9,100 -> 28
        feed(100);
        check_after_capture("slide", 28);

        // Constant windows
        for (int i = 0; i < 9; i++) feed(10);
        check_after_capture("const10", 22);
        for (int i = 0; i < 9; i++) feed(255);
        check_after_capture("const255_max", 573);

        // Reset with nonzero history
        do_reset("reset_midstream");

        // Fractional mean: eight 0s then 10 -> 1
        for (int i = 0; i < 8; i++) feed(0);
        feed(10);
        check_after_capture("frac_zero", 1);

        // Eight 3s then 30 -> 10
        for (int i = 0; i < 8; i++) feed(3);
        feed(30);
        check_after_capture("frac_three", 10);

        // Partially filled window after another reset
        do_reset("reset_again");
        feed(200);
        feed(17);
        feed(255);

        // Long random stream, with occasional runs of small/large values
        for (int n = 0; n < 2000; n++) begin
            int r;
            case ($urandom_range(0, 3))
                0:       r = $urandom_range(0, 7);
                1:       r = $urandom_range(248, 255);
                default: r = $urandom_range(0, 255);
            endcase
            feed(r);
        end

        repeat (3) @(posedge clk);
        #2;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results pending, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
